// File: rtl/fetch_sequencer.sv
// Stall-aware instruction fetch sequencer: owns the PC, runs req/gnt/rvalid against imem and valid/ready to decode.
// Define FETCH_MISALIGN_TRAP_EN to trap misaligned redirect targets in a FAULT state instead of aligning them.
module fetch_sequencer #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}}
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic            inst_valid,
    output logic [31:0]     inst,
    output logic [XLEN-1:0] inst_pc,
    input  logic            inst_ready,
    output logic            fetch_fault
);

    typedef enum logic [2:0] {
        ST_BOOT  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_HOLD  = 3'd3
`ifdef FETCH_MISALIGN_TRAP_EN
        , ST_FAULT = 3'd4
`endif
    } state_t;

    state_t          state_r, state_s;
    logic [XLEN-1:0] pc_r, pc_s;
    logic            kill_r, kill_s;
    logic            inst_valid_r, inst_valid_s;
    logic [31:0]     inst_r, inst_s;
    logic [XLEN-1:0] inst_pc_r, inst_pc_s;
    logic [XLEN-1:0] target_s;
    logic [XLEN-1:0] pc_plus4_s;
    logic            in_flight_s;

    assign pc_plus4_s = pc_r + {{(XLEN-3){1'b0}}, 3'b100};

`ifdef FETCH_MISALIGN_TRAP_EN
    logic misalign_s;
    logic fault_r, fault_s;

    assign target_s    = redirect_pc;
    assign misalign_s  = (redirect_pc[1:0] != 2'b00);
    // A response is still owed after this cycle when a grant lands now or a pending one has not yet returned.
    assign in_flight_s = ((state_r == ST_REQ)   && imem_gnt) ||
                         ((state_r == ST_WAIT)  && !imem_rvalid) ||
                         ((state_r == ST_FAULT) && kill_r && !imem_rvalid);
    assign fetch_fault = fault_r;
`else
    assign target_s    = redirect_pc & {{(XLEN-2){1'b1}}, 2'b00};
    assign in_flight_s = ((state_r == ST_REQ)  && imem_gnt) ||
                         ((state_r == ST_WAIT) && !imem_rvalid);
    assign fetch_fault = 1'b0;
`endif

    assign inst_valid = inst_valid_r;
    assign inst       = inst_r;
    assign inst_pc    = inst_pc_r;

    // State register and registered decode-side outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_BOOT;
            pc_r         <= RESET_PC;
            kill_r       <= 1'b0;
            inst_valid_r <= 1'b0;
            inst_r       <= 32'h0000_0000;
            inst_pc_r    <= {XLEN{1'b0}};
`ifdef FETCH_MISALIGN_TRAP_EN
            fault_r      <= 1'b0;
`endif
        end else begin
            state_r      <= state_s;
            pc_r         <= pc_s;
            kill_r       <= kill_s;
            inst_valid_r <= inst_valid_s;
            inst_r       <= inst_s;
            inst_pc_r    <= inst_pc_s;
`ifdef FETCH_MISALIGN_TRAP_EN
            fault_r      <= fault_s;
`endif
        end
    end

    // Next state; a redirect overrides everything, including a same-cycle decode handshake
    always_comb begin
        state_s      = state_r;
        pc_s         = pc_r;
        kill_s       = kill_r;
        inst_valid_s = inst_valid_r;
        inst_s       = inst_r;
        inst_pc_s    = inst_pc_r;
        if (redirect_valid) begin
            pc_s         = target_s;
            inst_valid_s = 1'b0;
            kill_s       = in_flight_s;
`ifdef FETCH_MISALIGN_TRAP_EN
            if (misalign_s) begin
                state_s = ST_FAULT;
            end else if (in_flight_s) begin
                state_s = ST_WAIT;
            end else begin
                state_s = ST_REQ;
            end
`else
            if (in_flight_s) begin
                state_s = ST_WAIT;
            end else begin
                state_s = ST_REQ;
            end
`endif
        end else begin
            case (state_r)
                ST_BOOT: begin
                    state_s = ST_REQ;
                end
                ST_REQ: begin
                    if (imem_gnt) begin
                        state_s = ST_WAIT;
                    end else begin
                        state_s = ST_REQ;
                    end
                end
                ST_WAIT: begin
                    if (imem_rvalid && kill_r) begin
                        kill_s  = 1'b0;
                        state_s = ST_REQ;
                    end else if (imem_rvalid) begin
                        inst_s       = imem_rdata;
                        inst_pc_s    = pc_r;
                        inst_valid_s = 1'b1;
                        state_s      = ST_HOLD;
                    end else begin
                        state_s = ST_WAIT;
                    end
                end
                ST_HOLD: begin
                    if (inst_ready) begin
                        pc_s         = pc_plus4_s;
                        inst_valid_s = 1'b0;
                        state_s      = ST_REQ;
                    end else begin
                        inst_valid_s = 1'b1;
                        state_s      = ST_HOLD;
                    end
                end
`ifdef FETCH_MISALIGN_TRAP_EN
                ST_FAULT: begin
                    if (imem_rvalid) begin
                        kill_s = 1'b0;
                    end else begin
                        kill_s = kill_r;
                    end
                end
`endif
                default: begin
                    state_s      = ST_BOOT;
                    kill_s       = 1'b0;
                    inst_valid_s = 1'b0;
                end
            endcase
        end
`ifdef FETCH_MISALIGN_TRAP_EN
        fault_s = (state_s == ST_FAULT);
`endif
    end

    // Memory request decodes straight from the state register
    always_comb begin
        imem_req  = 1'b0;
        imem_addr = {XLEN{1'b0}};
        if (state_r == ST_REQ) begin
            imem_req  = 1'b1;
            imem_addr = pc_r;
        end else begin
            imem_req  = 1'b0;
            imem_addr = {XLEN{1'b0}};
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: bench-side instruction memory plus a program-order PC model.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic        fetch_fault;

    int total = 0;
    int bad   = 0;

    bit          gnt_ok;
    int          rv_lat;
    bit          poison;
    bit          pend;
    int          pend_cnt;
    logic [31:0] pend_addr;

    logic [31:0] exp_pc;
    bit          exp_fault;
    int          hs_count = 0;

    logic        s_req, s_iv, s_fault;
    logic [31:0] s_addr, s_inst, s_ipc;

    fetch_sequencer #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
        .inst_ready(inst_ready), .fetch_fault(fetch_fault)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A3C_0F96;
    endfunction

    function automatic logic [31:0] fetch_target(input logic [31:0] a);
`ifdef FETCH_MISALIGN_TRAP_EN
        return a;
`else
        return {a[31:2], 2'b00};
`endif
    endfunction

    task automatic sample();
        s_req   = imem_req;
        s_addr  = imem_addr;
        s_iv    = inst_valid;
        s_inst  = inst;
        s_ipc   = inst_pc;
        s_fault = fetch_fault;
    endtask

    // One clock: present memory responses, update the program-order model, then check what the DUT shows.
    task automatic tick();
        logic        p_req, p_gnt, p_iv, p_redir, p_ready, resp;
        logic [31:0] p_addr, p_inst, p_ipc;
        resp        = pend && (pend_cnt == 1);
        imem_gnt    = s_req & gnt_ok;
        imem_rvalid = resp;
        imem_rdata  = resp ? (poison ? 32'hDEAD_BEEF : mem_word(pend_addr)) : $urandom;
        p_req = s_req; p_gnt = imem_gnt; p_iv = s_iv; p_redir = redirect_valid; p_ready = inst_ready;
        p_addr = s_addr; p_inst = s_inst; p_ipc = s_ipc;
        if (s_iv && inst_ready) begin
            total++;
            if (s_ipc !== exp_pc || s_inst !== mem_word(exp_pc)) begin
                bad++;
                $display("FAIL handshake: got pc=%h inst=%h, want pc=%h inst=%h", s_ipc, s_inst, exp_pc, mem_word(exp_pc));
            end
            hs_count++;
            exp_pc = exp_pc + 32'd4;
        end
        if (redirect_valid) begin
            exp_pc = fetch_target(redirect_pc);
`ifdef FETCH_MISALIGN_TRAP_EN
            exp_fault = (redirect_pc[1:0] != 2'b00);
`endif
        end
        if (resp) begin
            pend   = 1'b0;
            poison = 1'b0;
        end else if (pend) begin
            pend_cnt--;
        end
        if (s_req && imem_gnt) begin
            pend      = 1'b1;
            pend_cnt  = rv_lat;
            pend_addr = s_addr;
        end
        @(posedge clk);
        #1;
        sample();
        total++;
        if (s_fault !== exp_fault) begin
            bad++;
            $display("FAIL fault_flag: got %b want %b", s_fault, exp_fault);
        end
        if (s_req) begin
            total++;
            if (pend || exp_fault || s_addr !== exp_pc) begin
                bad++;
                $display("FAIL req_addr: got addr=%h (outstanding=%0d fault=%0d) want addr=%h, none outstanding", s_addr, pend, exp_fault, exp_pc);
            end
        end
        if (s_iv) begin
            total++;
            if (s_ipc !== exp_pc) begin
                bad++;
                $display("FAIL valid_pc: got %h want %h", s_ipc, exp_pc);
            end
        end
        if (p_redir) begin
            total++;
            if (s_iv !== 1'b0) begin
                bad++;
                $display("FAIL redirect_drop: got inst_valid=%b want 0", s_iv);
            end
        end
        if (p_req && !p_gnt && !p_redir) begin
            total++;
            if (s_req !== 1'b1 || s_addr !== p_addr) begin
                bad++;
                $display("FAIL addr_stable: got req=%b addr=%h want req=1 addr=%h", s_req, s_addr, p_addr);
            end
        end
        if (p_iv && !p_ready && !p_redir) begin
            total++;
            if (s_iv !== 1'b1 || s_inst !== p_inst || s_ipc !== p_ipc) begin
                bad++;
                $display("FAIL hold_stable: got v=%b inst=%h pc=%h want v=1 inst=%h pc=%h", s_iv, s_inst, s_ipc, p_inst, p_ipc);
            end
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; inst_ready = 1'b0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        pend = 1'b0; pend_cnt = 0; poison = 1'b0; exp_pc = 32'h0; exp_fault = 1'b0;
        gnt_ok = 1'b1; rv_lat = 1;
        #1;
        sample();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sample();
    endtask

    task automatic test_reset();
        do_reset();
        gnt_ok = 1'b1; rv_lat = 2; inst_ready = 1'b1;
        tick();
        tick();
        rst_n = 1'b0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0;
        pend = 1'b0; pend_cnt = 0; exp_pc = 32'h0; exp_fault = 1'b0;
        #1;
        sample();
        total++; if (s_req !== 1'b0) begin bad++; $display("FAIL rst_req: got %b want 0", s_req); end
        total++; if (s_iv !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", s_iv); end
        total++; if (s_inst !== 32'h0) begin bad++; $display("FAIL rst_inst: got %h want 0", s_inst); end
        total++; if (s_ipc !== 32'h0) begin bad++; $display("FAIL rst_inst_pc: got %h want 0", s_ipc); end
        total++; if (s_fault !== 1'b0) begin bad++; $display("FAIL rst_fault: got %b want 0", s_fault); end
        @(posedge clk);
        #1;
        rst_n = 1'b1; rv_lat = 1;
        sample();
        for (int k = 0; k < 3; k++) begin
            tick();
            total++;
            if (s_req !== 1'b1 || s_addr !== 32'(k * 4)) begin
                bad++;
                $display("FAIL seq_addr: got req=%b addr=%h want req=1 addr=%h", s_req, s_addr, 32'(k * 4));
            end
            tick();
            tick();
            total++;
            if (s_iv !== 1'b1 || s_ipc !== 32'(k * 4)) begin
                bad++;
                $display("FAIL seq_latency: got v=%b pc=%h want v=1 pc=%h", s_iv, s_ipc, 32'(k * 4));
            end
        end
    endtask

    task automatic test_gnt_stall();
        do_reset();
        inst_ready = 1'b1; gnt_ok = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if (s_req !== 1'b1 || s_addr !== 32'h0 || s_iv !== 1'b0) begin
                bad++;
                $display("FAIL gnt_stall: got req=%b addr=%h v=%b want req=1 addr=0 v=0", s_req, s_addr, s_iv);
            end
        end
        gnt_ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (s_iv) break;
        end
        total++;
        if (s_iv !== 1'b1 || s_ipc !== 32'h0) begin
            bad++;
            $display("FAIL gnt_resume: got v=%b pc=%h want v=1 pc=0", s_iv, s_ipc);
        end
        tick();
        total++;
        if (s_req !== 1'b1 || s_addr !== 32'h4) begin
            bad++;
            $display("FAIL gnt_next: got req=%b addr=%h want req=1 addr=4", s_req, s_addr);
        end
    endtask

    task automatic test_hold_stall();
        logic [31:0] h_inst;
        do_reset();
        inst_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (s_iv) break;
        end
        h_inst = s_inst;
        total++;
        if (s_iv !== 1'b1 || s_ipc !== 32'h0 || h_inst !== mem_word(32'h0)) begin
            bad++;
            $display("FAIL hold_first: got v=%b pc=%h inst=%h want v=1 pc=0 inst=%h", s_iv, s_ipc, h_inst, mem_word(32'h0));
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if (s_iv !== 1'b1 || s_inst !== h_inst || s_ipc !== 32'h0 || s_req !== 1'b0) begin
                bad++;
                $display("FAIL hold_wait: got v=%b inst=%h pc=%h req=%b want v=1 inst=%h pc=0 req=0", s_iv, s_inst, s_ipc, s_req, h_inst);
            end
        end
        inst_ready = 1'b1;
        tick();
        total++;
        if (s_iv !== 1'b0 || s_req !== 1'b1 || s_addr !== 32'h4) begin
            bad++;
            $display("FAIL hold_release: got v=%b req=%b addr=%h want v=0 req=1 addr=4", s_iv, s_req, s_addr);
        end
    endtask

    task automatic test_redirect_wait();
        bit          saw_bad, seen_req;
        logic [31:0] first_addr;
        do_reset();
        inst_ready = 1'b1; rv_lat = 3; poison = 1'b1;
        saw_bad = 1'b0; seen_req = 1'b0; first_addr = 32'hFFFF_FFFF;
        tick();
        tick();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
        tick();
        redirect_valid = 1'b0;
        rv_lat = 1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (s_iv && s_inst === 32'hDEAD_BEEF) saw_bad = 1'b1;
            if (s_req && !seen_req) begin
                seen_req   = 1'b1;
                first_addr = s_addr;
            end
            if (s_iv) break;
        end
        total++;
        if (saw_bad || first_addr !== 32'h0000_0100) begin
            bad++;
            $display("FAIL redirect_wait_addr: got stale=%0d addr=%h want stale=0 addr=00000100", saw_bad, first_addr);
        end
        total++;
        if (s_iv !== 1'b1 || s_ipc !== 32'h0000_0100 || s_inst !== mem_word(32'h0000_0100)) begin
            bad++;
            $display("FAIL redirect_wait_inst: got v=%b pc=%h inst=%h want v=1 pc=00000100 inst=%h", s_iv, s_ipc, s_inst, mem_word(32'h0000_0100));
        end
    endtask

    task automatic test_redirect_hs();
        do_reset();
        inst_ready = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0020;
        tick();
        redirect_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (s_iv) break;
        end
        total++;
        if (s_iv !== 1'b1 || s_ipc !== 32'h0000_0020) begin
            bad++;
            $display("FAIL hs_setup: got v=%b pc=%h want v=1 pc=00000020", s_iv, s_ipc);
        end
        inst_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0080;
        tick();
        redirect_valid = 1'b0; inst_ready = 1'b0;
        total++;
        if (s_req !== 1'b1 || s_addr !== 32'h0000_0080 || s_iv !== 1'b0) begin
            bad++;
            $display("FAIL redirect_beats_hs: got req=%b addr=%h v=%b want req=1 addr=00000080 v=0", s_req, s_addr, s_iv);
        end
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (s_iv) break;
        end
        total++;
        if (s_iv !== 1'b1 || s_ipc !== 32'hFFFF_FFFC) begin
            bad++;
            $display("FAIL wrap_setup: got v=%b pc=%h want v=1 pc=fffffffc", s_iv, s_ipc);
        end
        inst_ready = 1'b1;
        tick();
        total++;
        if (s_req !== 1'b1 || s_addr !== 32'h0) begin
            bad++;
            $display("FAIL wrap_addr: got req=%b addr=%h want req=1 addr=00000000", s_req, s_addr);
        end
    endtask

    task automatic test_misalign();
        do_reset();
        inst_ready = 1'b1;
`ifdef FETCH_MISALIGN_TRAP_EN
        tick();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0102;
        tick();
        redirect_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (s_fault !== 1'b1 || s_req !== 1'b0) begin
                bad++;
                $display("FAIL misalign_trap: got fault=%b req=%b want fault=1 req=0", s_fault, s_req);
            end
            tick();
        end
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
        tick();
        redirect_valid = 1'b0;
        total++;
        if (s_fault !== 1'b0 || s_req !== 1'b1 || s_addr !== 32'h0000_0200) begin
            bad++;
            $display("FAIL misalign_clear: got fault=%b req=%b addr=%h want fault=0 req=1 addr=00000200", s_fault, s_req, s_addr);
        end
`else
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0102;
        tick();
        redirect_valid = 1'b0;
        total++;
        if (s_fault !== 1'b0 || s_req !== 1'b1 || s_addr !== 32'h0000_0100) begin
            bad++;
            $display("FAIL misalign_align: got fault=%b req=%b addr=%h want fault=0 req=1 addr=00000100", s_fault, s_req, s_addr);
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            if (s_iv) break;
        end
        total++;
        if (s_iv !== 1'b1 || s_ipc !== 32'h0000_0100) begin
            bad++;
            $display("FAIL misalign_inst: got v=%b pc=%h want v=1 pc=00000100", s_iv, s_ipc);
        end
`endif
    endtask

    task automatic test_random();
        int hs_start;
        do_reset();
        hs_start = hs_count;
        for (int c = 0; c < 1500; c++) begin
            gnt_ok     = ($urandom_range(3) != 0);
            inst_ready = ($urandom_range(4) < 3);
            rv_lat     = int'($urandom_range(3, 1));
            if ($urandom_range(19) == 0) begin
                redirect_valid = 1'b1;
                if ($urandom_range(3) == 0) begin
                    redirect_pc = 32'hFFFF_FFF0 | ($urandom & 32'h0000_000F);
                end else begin
                    redirect_pc = $urandom & 32'h0000_0FFF;
                end
`ifdef FETCH_MISALIGN_TRAP_EN
                redirect_pc = redirect_pc & 32'hFFFF_FFFC;
`endif
            end else begin
                redirect_valid = 1'b0;
            end
            tick();
        end
        redirect_valid = 1'b0;
        total++;
        if (hs_count - hs_start < 50) begin
            bad++;
            $display("FAIL random_progress: got %0d handshakes want at least 50", hs_count - hs_start);
        end
    endtask

    initial begin
        rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; inst_ready = 1'b0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        s_req = 1'b0; s_iv = 1'b0; s_fault = 1'b0; s_addr = 32'h0; s_inst = 32'h0; s_ipc = 32'h0;
        test_reset();
        test_gnt_stall();
        test_hold_stall();
        test_redirect_wait();
        test_redirect_hs();
        test_misalign();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at time limit");
        $fatal(1, "time limit");
    end

endmodule
